alu_exec_stage: RTL and testbench

- Execution stage directly downstream of the ALU control decoder.
- Aligns register operands with the decoder's registered adder/logic controls, which arrive one cycle after issue.
- Computes the add/sub/logic result and holds it in a 2-entry result buffer.
- Drives the writeback stage over a valid/ready handshake.
- Throttles issue through stall_out, because the decoder cannot itself be stalled.

---
 rtl/alu_exec_stage_pkg.sv | 25 ++
 rtl/alu_exec_stage_buf.sv | 71 +++++++
 rtl/alu_exec_stage.sv | 126 ++++++++++++
 tb/tb_alu_exec_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared execution-stage encodings: adder and logic control codes
// produced by the ALU control decoder.
package alu_exec_stage_pkg;

   localparam int CTRL_ADD_WIDTH   = 2;
   localparam int CTRL_LOGIC_WIDTH = 3;

   // Adder control; encoding 2'd3 is unassigned and decodes as illegal.
   typedef enum logic [CTRL_ADD_WIDTH-1:0] {
      CTRL_ADD  = 2'd0,
      CTRL_SUB  = 2'd1,
      CTRL_ADDI = 2'd2
   } ctrl_add_e;

   // Logic control; encodings 3'd6 and 3'd7 are unassigned and decode as illegal.
   typedef enum logic [CTRL_LOGIC_WIDTH-1:0] {
      CTRL_OR   = 3'd0,
      CTRL_XOR  = 3'd1,
      CTRL_AND  = 3'd2,
      CTRL_ORI  = 3'd3,
      CTRL_XORI = 3'd4,
      CTRL_ANDI = 3'd5
   } ctrl_logic_e;

endpackage

// File: rtl/alu_exec_stage_buf.sv
// Small result FIFO between the ALU compute path and writeback.
// Holds {illegal, rd, data}; head is presented combinationally and
// reads as zero while the FIFO is empty.
module alu_result_buf
   import alu_exec_stage_pkg::*;
#(
   parameter int W     = 38,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;
   logic [W-1:0]     entry_q [DEPTH];

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop & ~empty;
   // A push at full is only allowed when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [W-1:0] entry_reg;
         // Capture the pushed word into the slot addressed by the write pointer.
         always_ff @(posedge clk) begin
            if (do_push && !reset && !flush && (wr_ptr_reg == PTR_W'(gi)))
               entry_reg <= din;
         end
         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   // Pointer and occupancy bookkeeping; reset and flush empty the FIFO.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
         if (do_pop)
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = empty ? '0 : entry_q[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execution stage: aligns operands with the decoder's one-cycle-late
// controls, computes add/sub/logic results and queues them for writeback.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RD_W      = 5,
   parameter int IMM_W     = 12,
   parameter int BUF_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        uop_valid_in,
   input  logic [XLEN-1:0]             rs1_data,
   input  logic [XLEN-1:0]             rs2_data,
   input  logic [IMM_W-1:0]            imm,
   input  logic [RD_W-1:0]             rd_addr,
   input  logic [CTRL_ADD_WIDTH-1:0]   ctrl_adder,
   input  logic                        uop_is_add,
   input  logic [CTRL_LOGIC_WIDTH-1:0] ctrl_logic,
   input  logic                        uop_is_logic,
   output logic                        stall_out,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [XLEN-1:0]             wb_data,
   output logic [RD_W-1:0]             wb_rd,
   output logic                        wb_illegal
);

   localparam int ENTRY_W = 1 + RD_W + XLEN;
   localparam int CNT_W   = $clog2(BUF_DEPTH+1);

   logic              a_valid_reg;
   logic [XLEN-1:0]   a_rs1_reg, a_rs2_reg, a_imm_reg;
   logic [RD_W-1:0]   a_rd_reg;

   logic              accept, pop;
   logic [XLEN-1:0]   res_data;
   logic              res_legal;
   logic [ENTRY_W-1:0] buf_din, buf_dout;
   logic [CNT_W-1:0]  buf_count;
   logic              buf_full, buf_empty;
   logic [CNT_W:0]    occupancy;

   assign accept = uop_valid_in & ~stall_out;
   assign pop    = wb_valid & wb_ready;

   // Projected occupancy after this edge; stalling at the buffer depth
   // guarantees the uop in stage A always has a free slot next cycle.
   assign occupancy = (CNT_W+1)'(buf_count) + (CNT_W+1)'(a_valid_reg);
   assign stall_out = occupancy >= ((CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop));

   // Stage A: hold operands for one cycle so they line up with the decoder controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid_reg <= 1'b0;
         a_rs1_reg   <= '0;
         a_rs2_reg   <= '0;
         a_imm_reg   <= '0;
         a_rd_reg    <= '0;
      end else begin
         a_valid_reg <= accept & ~flush;
         if (accept) begin
            a_rs1_reg <= rs1_data;
            a_rs2_reg <= rs2_data;
            a_imm_reg <= {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
            a_rd_reg  <= rd_addr;
         end
      end
   end

   // Result select; anything other than exactly one flag with a known code is illegal.
   always_comb begin
      res_data  = '0;
      res_legal = 1'b0;
      if (uop_is_add && !uop_is_logic) begin
         case (ctrl_adder)
            CTRL_ADD:  begin res_data = a_rs1_reg + a_rs2_reg; res_legal = 1'b1; end
            CTRL_SUB:  begin res_data = a_rs1_reg - a_rs2_reg; res_legal = 1'b1; end
            CTRL_ADDI: begin res_data = a_rs1_reg + a_imm_reg; res_legal = 1'b1; end
            default:   begin res_data = '0; res_legal = 1'b0; end
         endcase
      end else if (uop_is_logic && !uop_is_add) begin
         case (ctrl_logic)
            CTRL_OR:   begin res_data = a_rs1_reg | a_rs2_reg; res_legal = 1'b1; end
            CTRL_XOR:  begin res_data = a_rs1_reg ^ a_rs2_reg; res_legal = 1'b1; end
            CTRL_AND:  begin res_data = a_rs1_reg & a_rs2_reg; res_legal = 1'b1; end
            CTRL_ORI:  begin res_data = a_rs1_reg | a_imm_reg; res_legal = 1'b1; end
            CTRL_XORI: begin res_data = a_rs1_reg ^ a_imm_reg; res_legal = 1'b1; end
            CTRL_ANDI: begin res_data = a_rs1_reg & a_imm_reg; res_legal = 1'b1; end
            default:   begin res_data = '0; res_legal = 1'b0; end
         endcase
      end
   end

   // x0 writes always carry zero data; the illegal flag still travels with them.
   assign buf_din = {~res_legal, a_rd_reg,
                     (res_legal && (a_rd_reg != '0)) ? res_data : {XLEN{1'b0}}};

   alu_result_buf #(
      .W     (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (a_valid_reg),
      .pop   (pop),
      .din   (buf_din),
      .dout  (buf_dout),
      .count (buf_count),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign wb_valid   = ~buf_empty;
   assign wb_illegal = buf_dout[ENTRY_W-1];
   assign wb_rd      = buf_dout[XLEN +: RD_W];
   assign wb_data    = buf_dout[XLEN-1:0];

   // The stall rule must make a push into a full buffer without a pop impossible.
   overflow_never: assert property (@(posedge clk) disable iff (reset || flush)
                                    !(a_valid_reg && buf_full && !pop));

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases plus random traffic against a
// queue-based reference of issue, decode and writeback.
module tb_alu_exec_stage;
   import alu_exec_stage_pkg::*;

   localparam int XLEN = 32, RD_W = 5, IMM_W = 12;

   logic clk = 1'b0;
   logic reset, flush, uop_valid_in, uop_is_add, uop_is_logic, wb_ready;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [IMM_W-1:0] imm;
   logic [RD_W-1:0] rd_addr;
   logic [CTRL_ADD_WIDTH-1:0] ctrl_adder;
   logic [CTRL_LOGIC_WIDTH-1:0] ctrl_logic;
   logic stall_out, wb_valid, wb_illegal;
   logic [XLEN-1:0] wb_data;
   logic [RD_W-1:0] wb_rd;

   alu_exec_stage #(.XLEN(XLEN), .RD_W(RD_W), .IMM_W(IMM_W), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .flush(flush), .uop_valid_in(uop_valid_in),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_addr(rd_addr),
      .ctrl_adder(ctrl_adder), .uop_is_add(uop_is_add), .ctrl_logic(ctrl_logic),
      .uop_is_logic(uop_is_logic), .stall_out(stall_out), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_illegal(wb_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rs1, rs2;
      logic [11:0] imm;
      logic [4:0]  rd;
      logic        is_add, is_logic;
      logic [1:0]  cadd;
      logic [2:0]  clog;
   } uop_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];
   uop_t pend_u;
   logic pend_v = 1'b0;
   int   passed = 0, total = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: plain arithmetic on the operands, chosen by which single flag is set.
   function automatic exp_t ref_model(uop_t u);
      exp_t e;
      logic [31:0] ix, r;
      logic ok;
      ix = 32'($signed(u.imm));
      r  = 32'h0;
      ok = 1'b0;
      if (u.is_add && !u.is_logic) begin
         if (u.cadd == CTRL_ADD)       begin r = u.rs1 + u.rs2; ok = 1'b1; end
         else if (u.cadd == CTRL_SUB)  begin r = u.rs1 - u.rs2; ok = 1'b1; end
         else if (u.cadd == CTRL_ADDI) begin r = u.rs1 + ix;    ok = 1'b1; end
      end else if (u.is_logic && !u.is_add) begin
         if (u.clog == CTRL_OR)        begin r = u.rs1 | u.rs2; ok = 1'b1; end
         else if (u.clog == CTRL_XOR)  begin r = u.rs1 ^ u.rs2; ok = 1'b1; end
         else if (u.clog == CTRL_AND)  begin r = u.rs1 & u.rs2; ok = 1'b1; end
         else if (u.clog == CTRL_ORI)  begin r = u.rs1 | ix;    ok = 1'b1; end
         else if (u.clog == CTRL_XORI) begin r = u.rs1 ^ ix;    ok = 1'b1; end
         else if (u.clog == CTRL_ANDI) begin r = u.rs1 & ix;    ok = 1'b1; end
      end
      e.ill  = !ok;
      e.rd   = u.rd;
      e.data = (ok && u.rd != 5'd0) ? r : 32'h0;
      return e;
   endfunction

   // op: 0 ADD 1 SUB 2 ADDI 3 OR 4 XOR 5 AND 6 ORI 7 XORI 8 ANDI
   //     9 both flags 10 no flag 11 bad adder code 12 bad logic code
   function automatic uop_t mk(int op, logic [31:0] a, logic [31:0] b, logic [11:0] i, logic [4:0] d);
      uop_t u;
      u.rs1 = a; u.rs2 = b; u.imm = i; u.rd = d;
      u.is_add = 1'b0; u.is_logic = 1'b0; u.cadd = CTRL_ADD; u.clog = CTRL_OR;
      case (op)
         0:  begin u.is_add = 1'b1; u.cadd = CTRL_ADD;  end
         1:  begin u.is_add = 1'b1; u.cadd = CTRL_SUB;  end
         2:  begin u.is_add = 1'b1; u.cadd = CTRL_ADDI; end
         3:  begin u.is_logic = 1'b1; u.clog = CTRL_OR;   end
         4:  begin u.is_logic = 1'b1; u.clog = CTRL_XOR;  end
         5:  begin u.is_logic = 1'b1; u.clog = CTRL_AND;  end
         6:  begin u.is_logic = 1'b1; u.clog = CTRL_ORI;  end
         7:  begin u.is_logic = 1'b1; u.clog = CTRL_XORI; end
         8:  begin u.is_logic = 1'b1; u.clog = CTRL_ANDI; end
         9:  begin u.is_add = 1'b1; u.is_logic = 1'b1; end
         10: begin end
         11: begin u.is_add = 1'b1; u.cadd = 2'd3; end
         default: begin u.is_logic = 1'b1; u.clog = 3'($urandom_range(6, 7)); end
      endcase
      return u;
   endfunction

   function automatic uop_t rnd_uop();
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
      return mk($urandom_range(0, 12), a, b, 12'($urandom), 5'($urandom_range(0, 31)));
   endfunction

   // One clock cycle: drive inputs after the falling edge, check state-driven
   // outputs 1 time unit later, then advance the model across the rising edge.
   task automatic step(input logic want_v, input uop_t u, input logic rdy,
                       input logic fl, input logic rst, output logic acc);
      logic exp_pop, exp_stall;
      uop_t junk;
      junk      = rnd_uop();
      exp_pop   = rdy && (q.size() > 0);
      exp_stall = (q.size() + int'(pend_v) - int'(exp_pop)) >= 2;
      acc       = want_v && !exp_stall;
      uop_valid_in = acc;
      rs1_data = u.rs1; rs2_data = u.rs2; imm = u.imm; rd_addr = u.rd;
      if (pend_v) begin
         uop_is_add = pend_u.is_add; uop_is_logic = pend_u.is_logic;
         ctrl_adder = pend_u.cadd;   ctrl_logic   = pend_u.clog;
      end else begin
         uop_is_add = junk.is_add; uop_is_logic = junk.is_logic;
         ctrl_adder = junk.cadd;   ctrl_logic   = junk.clog;
      end
      wb_ready = rdy; flush = fl; reset = rst;
      #1;
      chk("stall_out", 32'(stall_out), 32'(exp_stall));
      chk("wb_valid", 32'(wb_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("wb_data", wb_data, q[0].data);
         chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
         chk("wb_illegal", 32'(wb_illegal), 32'(q[0].ill));
      end
      if (rst || fl) begin
         q.delete();
         pend_v = 1'b0;
      end else begin
         if (exp_pop) void'(q.pop_front());
         if (pend_v) q.push_back(ref_model(pend_u));
         pend_v = acc;
         pend_u = u;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input uop_t u, input logic rdy);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) step(1'b1, u, rdy, 1'b0, 1'b0, acc);
      chk("issue_accept", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n, input logic rdy);
      logic acc;
      for (int k = 0; k < n; k++) step(1'b0, rnd_uop(), rdy, 1'b0, 1'b0, acc);
   endtask

   // Issue one uop into an empty stage and check its result lands exactly two cycles later.
   task automatic directed(input string tag, input uop_t u, input logic [31:0] exp_data, input logic exp_ill);
      idle(3, 1'b1);
      issue(u, 1'b1);
      chk({tag, "_lat1_valid"}, 32'(wb_valid), 32'd0);
      idle(1, 1'b1);
      chk({tag, "_lat2_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, "_data"}, wb_data, exp_data);
      chk({tag, "_illegal"}, 32'(wb_illegal), 32'(exp_ill));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_wb_illegal"}, 32'(wb_illegal), 32'd0);
      chk({tag, "_stall"}, 32'(stall_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      uop_t u;
      reset = 1'b1; flush = 1'b0; uop_valid_in = 1'b0; wb_ready = 1'b0;
      rs1_data = '0; rs2_data = '0; imm = '0; rd_addr = '0;
      ctrl_adder = '0; ctrl_logic = '0; uop_is_add = 1'b0; uop_is_logic = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      directed("add",  mk(0, 32'd5, 32'd7, 12'h0, 5'd3), 32'd12, 1'b0);
      chk("add_rd", 32'(wb_rd), 32'd3);
      directed("sub_wrap", mk(1, 32'd0, 32'd1, 12'h0, 5'd4), 32'hFFFF_FFFF, 1'b0);
      directed("addi_sext", mk(2, 32'h10, 32'h0, 12'hFFF, 5'd5), 32'h0000_000F, 1'b0);
      directed("or",   mk(3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h0, 5'd6), 32'hFFF0_FFF0, 1'b0);
      directed("xor",  mk(4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h0, 5'd7), 32'hFF00_FF00, 1'b0);
      directed("andi", mk(8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h0FF, 5'd8), 32'h0000_00F0, 1'b0);
      directed("both_flags", mk(9, 32'd9, 32'd9, 12'h1, 5'd9), 32'd0, 1'b1);
      directed("no_flag", mk(10, 32'd9, 32'd9, 12'h1, 5'd10), 32'd0, 1'b1);
      directed("bad_add_code", mk(11, 32'd9, 32'd9, 12'h1, 5'd11), 32'd0, 1'b1);
      directed("rd0_add", mk(0, 32'd5, 32'd7, 12'h0, 5'd0), 32'd0, 1'b0);

      // Back-to-back issue with writeback always ready: never stalls.
      idle(3, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, mk(0, 32'(i * 100), 32'(i), 12'h0, 5'(i + 1)), 1'b1, 1'b0, 1'b0, acc);
         chk("b2b_accept", 32'(acc), 32'd1);
      end
      idle(4, 1'b1);

      // Backpressure: two accepted, then held until the first pop.
      issue(mk(0, 32'd1, 32'd1, 12'h0, 5'd1), 1'b0);
      issue(mk(1, 32'd10, 32'd3, 12'h0, 5'd2), 1'b0);
      u = mk(4, 32'hAAAA_0000, 32'h0000_5555, 12'h0, 5'd3);
      step(1'b1, u, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_hold1", 32'(acc), 32'd0);
      chk("bp_stall", 32'(stall_out), 32'd1);
      chk("bp_head_data", wb_data, 32'd2);
      step(1'b1, u, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_hold2", 32'(acc), 32'd0);
      step(1'b1, u, 1'b1, 1'b0, 1'b0, acc);
      chk("bp_release", 32'(acc), 32'd1);
      chk("bp_second", wb_data, 32'd7);
      issue(mk(6, 32'h1000, 32'h0, 12'h800, 5'd4), 1'b1);
      idle(4, 1'b1);

      // Flush with two buffered; a uop accepted in the flush cycle is dropped.
      issue(mk(0, 32'd3, 32'd4, 12'h0, 5'd1), 1'b0);
      issue(mk(0, 32'd5, 32'd6, 12'h0, 5'd2), 1'b0);
      idle(1, 1'b0);
      step(1'b1, mk(0, 32'd7, 32'd8, 12'h0, 5'd3), 1'b1, 1'b1, 1'b0, acc);
      chk("flush_cycle_accept", 32'(acc), 32'd1);
      chk("flush_valid", 32'(wb_valid), 32'd0);
      idle(3, 1'b1);

      // Flush with one buffered and one in stage A.
      issue(mk(0, 32'd3, 32'd4, 12'h0, 5'd1), 1'b0);
      issue(mk(0, 32'd5, 32'd6, 12'h0, 5'd2), 1'b0);
      step(1'b0, rnd_uop(), 1'b0, 1'b1, 1'b0, acc);
      chk("flush_a_valid", 32'(wb_valid), 32'd0);
      idle(3, 1'b1);

      // Random traffic with random backpressure and rare flushes.
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 3) != 0, rnd_uop(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0, 1'b0, acc);
      idle(4, 1'b1);

      // Reset in the middle of a burst discards everything.
      issue(mk(0, 32'd11, 32'd22, 12'h0, 5'd7), 1'b0);
      issue(mk(4, 32'd11, 32'd22, 12'h0, 5'd8), 1'b0);
      step(1'b0, rnd_uop(), 1'b0, 1'b0, 1'b1, acc);
      reset = 1'b0;
      chk_zero("reset_mid");
      idle(3, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
